// File: rtl/rf_wb_scheduler.sv
// Round-robin writeback scheduler for the single register-file write port, with a
// per-register busy scoreboard for RAW stalls. Optional bypass: `define RF_WB_BYPASS_EN.
module rf_wb_scheduler #(
    parameter int NUM_SRC    = 2,
    parameter int REG_NUM    = 32,
    parameter int REG_WIDTH  = 5,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_SRC-1:0]              src_valid,
    output logic [NUM_SRC-1:0]              src_ready,
    input  logic [NUM_SRC*REG_WIDTH-1:0]    src_addr,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]   src_data,
    input  logic                            iss_en,
    input  logic [REG_WIDTH-1:0]            iss_addr,
    input  logic [REG_WIDTH-1:0]            rs_addr,
    input  logic [REG_WIDTH-1:0]            rt_addr,
    output logic                            rs_busy,
    output logic                            rt_busy,
    output logic                            rs_fwd_valid,
    output logic [DATA_WIDTH-1:0]           rs_fwd_data,
    output logic                            rt_fwd_valid,
    output logic [DATA_WIDTH-1:0]           rt_fwd_data,
    output logic                            rd_en,
    output logic [REG_WIDTH-1:0]            rd_addr,
    output logic [DATA_WIDTH-1:0]           rd_data
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [PTR_W-1:0]      rr_ptr;
    logic [PTR_W-1:0]      ptr_next;
    logic                  grant_vld;
    logic [PTR_W-1:0]      grant_idx;
    logic [REG_WIDTH-1:0]  grant_addr;
    logic [DATA_WIDTH-1:0] grant_data;
    logic [REG_NUM-1:0]    busy;
    logic [REG_NUM-1:0]    busy_next;
    logic                  wb_en_p1;
    logic [REG_WIDTH-1:0]  wb_addr_p1;
    logic [DATA_WIDTH-1:0] wb_data_p1;

    // Two passes give a wrapping search: sources at or above the pointer first, then the rest.
    always_comb begin
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_addr = '0;
        grant_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!grant_vld && src_valid[i] && (i >= int'(rr_ptr))) begin
                grant_vld  = 1'b1;
                grant_idx  = PTR_W'(i);
                grant_addr = src_addr[i*REG_WIDTH +: REG_WIDTH];
                grant_data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!grant_vld && src_valid[i]) begin
                grant_vld  = 1'b1;
                grant_idx  = PTR_W'(i);
                grant_addr = src_addr[i*REG_WIDTH +: REG_WIDTH];
                grant_data = src_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        src_ready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            src_ready[i] = grant_vld && !reset && (grant_idx == PTR_W'(i));
        end
    end

    always_comb begin
        ptr_next = grant_idx + 1'b1;
        if (grant_idx == PTR_W'(NUM_SRC - 1)) begin
            ptr_next = '0;
        end
    end

    // Clear from the write in flight, then set from issue so a same-edge set wins.
    always_comb begin
        busy_next = busy;
        if (wb_en_p1) begin
            busy_next[wb_addr_p1] = 1'b0;
        end
        if (iss_en) begin
            busy_next[iss_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Stage p1: registered register-file write port
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr     <= '0;
            busy       <= '0;
            wb_en_p1   <= 1'b0;
            wb_addr_p1 <= '0;
            wb_data_p1 <= '0;
        end else begin
            busy     <= busy_next;
            wb_en_p1 <= grant_vld && (grant_addr != '0);
            if (grant_vld) begin
                rr_ptr     <= ptr_next;
                wb_addr_p1 <= grant_addr;
                wb_data_p1 <= grant_data;
            end
        end
    end

    assign rd_en   = wb_en_p1;
    assign rd_addr = wb_addr_p1;
    assign rd_data = wb_data_p1;

    assign rs_busy = busy[rs_addr];
    assign rt_busy = busy[rt_addr];

`ifdef RF_WB_BYPASS_EN
    assign rs_fwd_valid = wb_en_p1 && (wb_addr_p1 == rs_addr) && (rs_addr != '0);
    assign rs_fwd_data  = wb_data_p1;
    assign rt_fwd_valid = wb_en_p1 && (wb_addr_p1 == rt_addr) && (rt_addr != '0);
    assign rt_fwd_data  = wb_data_p1;
`else
    assign rs_fwd_valid = 1'b0;
    assign rs_fwd_data  = '0;
    assign rt_fwd_valid = 1'b0;
    assign rt_fwd_data  = '0;
`endif

endmodule

// File: doc/rf_wb_scheduler.md
Name: rf_wb_scheduler

Overview:
- Shares the register file's single write port (rd_en/rd_addr/rd_data) among NUM_SRC writeback requesters, for example pipeline WB, load unit and mul/div unit.
- Uses a round-robin arbiter with a valid/ready handshake per source and a registered output stage that drives the register file write port.
- Holds a per-register busy scoreboard: the issue logic sets a register's bit, and completed writebacks clear it.
- Decode uses the scoreboard to stall on RAW hazards for rs/rt.

Parameters:
- NUM_SRC, 2, number of writeback requesters (2..4).
- REG_NUM, 32, number of architectural registers.
- REG_WIDTH, 5, register address width (log2 REG_NUM).
- DATA_WIDTH, 32, register data width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset.
- src_valid  in  NUM_SRC  per-source writeback request.
- src_ready  out  NUM_SRC  per-source grant; one-hot or zero.
- src_addr  in  NUM_SRC*REG_WIDTH  packed destination register; source i at slice [i*REG_WIDTH +: REG_WIDTH].
- src_data  in  NUM_SRC*DATA_WIDTH  packed write data, same packing.
- iss_en  in  1  instruction issued that writes iss_addr.
- iss_addr  in  REG_WIDTH  destination register of the issued instruction.
- rs_addr  in  REG_WIDTH  hazard query address A.
- rt_addr  in  REG_WIDTH  hazard query address B.
- rs_busy  out  1  busy[rs_addr]; combinational.
- rt_busy  out  1  busy[rt_addr]; combinational.
- rs_fwd_valid  out  1  forward hit for rs (optional feature).
- rs_fwd_data  out  DATA_WIDTH  forward data for rs (optional feature).
- rt_fwd_valid  out  1  forward hit for rt (optional feature).
- rt_fwd_data  out  DATA_WIDTH  forward data for rt (optional feature).
- rd_en  out  1  register file write enable; registered.
- rd_addr  out  REG_WIDTH  register file write address; registered.
- rd_data  out  DATA_WIDTH  register file write data; registered.

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high.
- Reset state: rd_en=0, rd_addr=0, rd_data=0, all busy bits 0, round-robin pointer=0 (source 0 has highest priority).
  - src_ready is forced to 0 while reset is high.
  - A grant issued in the cycle reset is asserted is discarded.
- Arbitration (combinational, every cycle):
  - Search starts at pointer p and wraps modulo NUM_SRC; the first source with valid=1 is granted.
  - src_ready[g]=1 in the same cycle. A transfer occurs when valid&&ready.
  - After a grant, p <= (g+1) mod NUM_SRC. With no grant, p is unchanged.
- Source rules:
  - A source holds valid, addr and data stable until it is granted.
  - The scheduler never stalls the output stage, so one transfer is possible every cycle.
- Latency: for a grant in cycle N, the register file write port outputs (rd_en/rd_addr/rd_data) present the write in cycle N+1 for exactly one cycle. The register file captures it at the end of N+1.
  - rd_en=1 iff a grant with addr!=0 occurred in N.
  - If no grant occurred in N, rd_en=0 and rd_addr/rd_data hold their previous values.
- Register 0:
  - A writeback to addr 0 is accepted (ready=1) but produces rd_en=0.
  - iss_en with iss_addr=0 has no effect.
  - busy[0] is always 0.
- Scoreboard:
  - iss_en sets busy[iss_addr] at the clock edge.
  - The bit clears at the edge where rd_en=1 for that address, i.e. the end of N+1, the same edge the register file writes. It therefore reads 0 from N+2.
  - If a set and a clear hit the same register on the same edge, the set wins.
  - iss_en to a register that is already busy is a protocol violation; the behaviour is that busy stays 1.
- Query outputs rs_busy/rt_busy are purely combinational from the busy vector.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Defined:
  - rs_fwd_valid = rd_en && rd_addr==rs_addr && rs_addr!=0.
  - rs_fwd_data = rd_data.
  - rt_fwd_valid and rt_fwd_data follow the same rules using rt_addr.
  - This lets decode consume, in cycle N+1, a value still busy in the scoreboard.
- Not defined: all four fwd outputs are tied to 0. The ports remain present.

Test Plan:
- Reset held for 3 cycles with src_valid=2'b11 -> src_ready=0, rd_en=0, rd_addr=0, rd_data=0, rs_busy=0. After release, the first grant goes to source 0.
- Source 0 only: valid with addr=5, data=32'hDEADBEEF in cycle N -> src_ready[0]=1 in N; rd_en=1, rd_addr=5, rd_data=32'hDEADBEEF in N+1; rd_en=0 in N+2.
- Both sources valid for 4 cycles with different addresses -> grants go 0,1,0,1, and rd_addr follows the same order with 1-cycle lag.
- iss_en addr=7 at cycle M -> rs_busy=1 with rs_addr=7 from M+1. Source 1 writeback to 7 granted at N -> rs_busy=1 in N+1 and 0 in N+2. With RF_WB_BYPASS_EN: rs_fwd_valid=1 and rs_fwd_data=the written value in N+1.
- Writeback addr=0 data=1 -> src_ready=1 and rd_en stays 0. iss_en addr=0 -> rs_busy with rs_addr=0 stays 0.
- busy[9]=1; iss_en addr=9 on the same edge that rd_en=1 with rd_addr=9 -> busy[9] remains 1 afterwards.
